// File: rtl/soc_system_cpu_s1_oci_dct_packer_if.sv
// Handshake and trace-observation bundle between the OCI data-trace logic and the DCT packer.
// The slave side is the packer. The master side is the code producer and the packet consumer.
interface soc_system_cpu_s1_oci_dct_packer_if #(
  parameter int SLOTS = 15
);
  logic                   trc_on;
  logic                   dct_in_valid;
  logic [1:0]             dct_in_code;
  logic                   dct_in_ready;
  logic                   flush;
  logic                   pkt_valid;
  logic [3+2*SLOTS:0]     pkt_data;
  logic                   pkt_ready;
  logic [2*SLOTS-1:0]     dct_buffer;
  logic [3:0]             dct_count;

  modport master (
    output trc_on, dct_in_valid, dct_in_code, flush, pkt_ready,
    input  dct_in_ready, pkt_valid, pkt_data, dct_buffer, dct_count
  );

  modport slave (
    input  trc_on, dct_in_valid, dct_in_code, flush, pkt_ready,
    output dct_in_ready, pkt_valid, pkt_data, dct_buffer, dct_count
  );
endinterface

// File: rtl/soc_system_cpu_s1_oci_dct_packer.sv
// Packs 2-bit DCT codes into a SLOTS-deep shift accumulator and emits full or flushed
// buffers through a one-deep hold register, so accumulation continues while a packet waits.
module soc_system_cpu_s1_oci_dct_packer #(
  parameter int SLOTS = 15
) (
  input  logic                                 clk,
  input  logic                                 reset,
  soc_system_cpu_s1_oci_dct_packer_if.slave    bus
);
  localparam int W  = 2 * SLOTS;
  localparam int PW = 4 + W;
  localparam logic [3:0] LAST = 4'(SLOTS - 1);

  logic [W-1:0]  acc_buf_q, acc_buf_d;
  logic [3:0]    acc_cnt_q, acc_cnt_d;
  logic          pkt_valid_q, pkt_valid_d;
  logic [PW-1:0] pkt_data_q, pkt_data_d;
  logic          flush_pend_q, flush_pend_d;

  logic          in_ready;
  logic          accept;
  logic          flush_req;
  logic [W-1:0]  buf_acc;
  logic [3:0]    cnt_acc;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    // Ready only drops when a fill would need the occupied hold register.
    in_ready  = !bus.trc_on || !(pkt_valid_q && (acc_cnt_q == LAST));
    accept    = bus.dct_in_valid && in_ready && bus.trc_on;
    flush_req = flush_pend_q || bus.flush;

    buf_acc = acc_buf_q;
    cnt_acc = acc_cnt_q;
    if (accept) begin
      buf_acc = {acc_buf_q[W-3:0], bus.dct_in_code};
      cnt_acc = acc_cnt_q + 4'd1;
    end

    acc_buf_d    = buf_acc;
    acc_cnt_d    = cnt_acc;
    pkt_valid_d  = pkt_valid_q && !bus.pkt_ready;
    pkt_data_d   = pkt_data_q;
    flush_pend_d = flush_req;

    // A flush completes whenever the hold register is free, even if nothing is buffered.
    if (flush_req && !pkt_valid_q) flush_pend_d = 1'b0;

    // Fill and flush load the same image: count and buffer after this cycle's accept.
    if ((accept && (acc_cnt_q == LAST)) ||
        (flush_req && !pkt_valid_q && (cnt_acc != 4'd0))) begin
      pkt_data_d  = {cnt_acc, buf_acc};
      pkt_valid_d = 1'b1;
      acc_buf_d   = '0;
      acc_cnt_d   = 4'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_buf_q    <= '0;
      acc_cnt_q    <= 4'd0;
      pkt_valid_q  <= 1'b0;
      pkt_data_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      acc_buf_q    <= acc_buf_d;
      acc_cnt_q    <= acc_cnt_d;
      pkt_valid_q  <= pkt_valid_d;
      pkt_data_q   <= pkt_data_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.dct_in_ready = in_ready;
  assign bus.pkt_valid    = pkt_valid_q;
  assign bus.pkt_data     = pkt_data_q;
  assign bus.dct_buffer   = acc_buf_q;
  assign bus.dct_count    = acc_cnt_q;
endmodule

// File: tb/tb_soc_system_cpu_s1_oci_dct_packer.sv
// Directed bench for the DCT packer: fill, flush, empty flush, stall, pending flush,
// trace-off dropping and asynchronous reset mid-packet.
module tb_soc_system_cpu_s1_oci_dct_packer;
  localparam int SLOTS = 15;
  localparam int W     = 2 * SLOTS;
  localparam int PW    = 4 + W;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  soc_system_cpu_s1_oci_dct_packer_if #(.SLOTS(SLOTS)) bus ();

  soc_system_cpu_s1_oci_dct_packer #(.SLOTS(SLOTS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [1:0] code_of(input int i);
    return 2'((i * 3 + i / 5) % 4);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_code(input logic [1:0] c);
    bus.dct_in_valid = 1'b1;
    bus.dct_in_code  = c;
    step();
    bus.dct_in_valid = 1'b0;
    bus.dct_in_code  = 2'd0;
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    bus.trc_on       = 1'b1;
    bus.dct_in_valid = 1'b0;
    bus.dct_in_code  = 2'd0;
    bus.flush        = 1'b0;
    bus.pkt_ready    = 1'b1;
    step();
    step();
    n_checks++;
    if (bus.pkt_valid !== 1'b0 || bus.pkt_data !== '0) begin
      n_fail++;
      $display("FAIL reset_pkt: got valid=%0b data=%h want valid=0 data=0", bus.pkt_valid, bus.pkt_data);
    end
    n_checks++;
    if (bus.dct_count !== 4'd0 || bus.dct_buffer !== '0 || bus.dct_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_acc: got cnt=%0d buf=%h rdy=%0b want 0 0 1", bus.dct_count, bus.dct_buffer, bus.dct_in_ready);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_fill();
    logic [W-1:0] exp_buf;
    exp_buf = '0;
    for (int i = 0; i < SLOTS; i++) begin
      exp_buf = {exp_buf[W-3:0], 2'(i % 4)};
      send_code(2'(i % 4));
      if (i == 0) begin
        n_checks++;
        if (bus.dct_count !== 4'd1) begin
          n_fail++;
          $display("FAIL fill_count_latency: got %0d want 1", bus.dct_count);
        end
      end
    end
    n_checks++;
    if (bus.pkt_valid !== 1'b1 || bus.pkt_data[33:30] !== 4'd15) begin
      n_fail++;
      $display("FAIL fill_hdr: got valid=%0b cnt=%0d want 1 15", bus.pkt_valid, bus.pkt_data[33:30]);
    end
    n_checks++;
    if (bus.pkt_data[1:0] !== 2'd2 || bus.pkt_data[29:28] !== 2'd0) begin
      n_fail++;
      $display("FAIL fill_ends: got newest=%0d oldest=%0d want 2 0", bus.pkt_data[1:0], bus.pkt_data[29:28]);
    end
    n_checks++;
    if (bus.pkt_data !== {4'd15, exp_buf} || bus.dct_count !== 4'd0) begin
      n_fail++;
      $display("FAIL fill_data: got %h cnt=%0d want %h cnt=0", bus.pkt_data, bus.dct_count, {4'd15, exp_buf});
    end
    step();
    n_checks++;
    if (bus.pkt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_drain: got valid=%0b want 0", bus.pkt_valid);
    end
  endtask

  task automatic test_flush();
    logic [1:0] codes [5] = '{2'd3, 2'd3, 2'd1, 2'd0, 2'd2};
    foreach (codes[i]) send_code(codes[i]);
    n_checks++;
    if (bus.dct_buffer !== W'(10'h3D2) || bus.dct_count !== 4'd5) begin
      n_fail++;
      $display("FAIL flush_acc: got buf=%h cnt=%0d want 3d2 5", bus.dct_buffer, bus.dct_count);
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    n_checks++;
    if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== 34'h1_4000_03D2) begin
      n_fail++;
      $display("FAIL flush_pkt: got valid=%0b data=%h want 1 140003d2", bus.pkt_valid, bus.pkt_data);
    end
    n_checks++;
    if (bus.dct_count !== 4'd0 || bus.dct_buffer !== '0) begin
      n_fail++;
      $display("FAIL flush_clear: got cnt=%0d buf=%h want 0 0", bus.dct_count, bus.dct_buffer);
    end
    step();
  endtask

  task automatic test_flush_empty();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    n_checks++;
    if (bus.pkt_valid !== 1'b0 || dut.flush_pend_q !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty: got valid=%0b pend=%0b want 0 0", bus.pkt_valid, dut.flush_pend_q);
    end
    step();
    n_checks++;
    if (bus.pkt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty_late: got valid=%0b want 0", bus.pkt_valid);
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [W-1:0] exp1, exp2;
    exp1 = '0;
    exp2 = '0;
    bus.pkt_ready = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      exp1 = {exp1[W-3:0], code_of(i)};
      send_code(code_of(i));
    end
    for (int i = 16; i <= 29; i++) begin
      exp2 = {exp2[W-3:0], code_of(i)};
      send_code(code_of(i));
    end
    exp2 = {exp2[W-3:0], code_of(30)};
    n_checks++;
    if (bus.dct_count !== 4'd14 || bus.dct_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_state: got cnt=%0d rdy=%0b want 14 0", bus.dct_count, bus.dct_in_ready);
    end
    bus.dct_in_valid = 1'b1;
    bus.dct_in_code  = code_of(30);
    step();
    n_checks++;
    if (bus.dct_count !== 4'd14 || bus.pkt_data !== {4'd15, exp1} || bus.pkt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hold: got cnt=%0d data=%h want 14 %h", bus.dct_count, bus.pkt_data, {4'd15, exp1});
    end
    bus.pkt_ready = 1'b1;
    step();
    bus.pkt_ready = 1'b0;
    n_checks++;
    if (bus.pkt_valid !== 1'b0 || bus.dct_in_ready !== 1'b1 || bus.dct_count !== 4'd14) begin
      n_fail++;
      $display("FAIL stall_release: got valid=%0b rdy=%0b cnt=%0d want 0 1 14", bus.pkt_valid, bus.dct_in_ready, bus.dct_count);
    end
    step();
    bus.dct_in_valid = 1'b0;
    n_checks++;
    if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== {4'd15, exp2} || bus.dct_count !== 4'd0) begin
      n_fail++;
      $display("FAIL stall_second_pkt: got %h cnt=%0d want %h 0", bus.pkt_data, bus.dct_count, {4'd15, exp2});
    end
    bus.pkt_ready = 1'b1;
    step();
  endtask

  task automatic test_flush_pending();
    logic [W-1:0] exp_buf;
    exp_buf = '0;
    bus.pkt_ready = 1'b0;
    for (int i = 0; i < SLOTS; i++) send_code(code_of(i + 40));
    for (int i = 0; i < 3; i++) begin
      exp_buf = {exp_buf[W-3:0], code_of(i + 60)};
      send_code(code_of(i + 60));
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    n_checks++;
    if (bus.pkt_valid !== 1'b1 || bus.pkt_data[33:30] !== 4'd15 || bus.dct_count !== 4'd3 || dut.flush_pend_q !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_held: got valid=%0b cnt=%0d acc=%0d pend=%0b want 1 15 3 1", bus.pkt_valid, bus.pkt_data[33:30], bus.dct_count, dut.flush_pend_q);
    end
    for (int i = 3; i < 5; i++) begin
      exp_buf = {exp_buf[W-3:0], code_of(i + 60)};
      send_code(code_of(i + 60));
    end
    bus.pkt_ready = 1'b1;
    step();
    bus.pkt_ready = 1'b0;
    n_checks++;
    if (bus.pkt_valid !== 1'b0 || bus.dct_count !== 4'd5) begin
      n_fail++;
      $display("FAIL pend_drain: got valid=%0b cnt=%0d want 0 5", bus.pkt_valid, bus.dct_count);
    end
    step();
    n_checks++;
    if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== {4'd5, exp_buf} || dct_state_nonzero()) begin
      n_fail++;
      $display("FAIL pend_flush_pkt: got valid=%0b data=%h cnt=%0d want 1 %h 0", bus.pkt_valid, bus.pkt_data, bus.dct_count, {4'd5, exp_buf});
    end
    n_checks++;
    if (dut.flush_pend_q !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_clear: got pend=%0b want 0", dut.flush_pend_q);
    end
    bus.pkt_ready = 1'b1;
    step();
  endtask

  function automatic logic dct_state_nonzero();
    return (bus.dct_count !== 4'd0) || (bus.dct_buffer !== '0);
  endfunction

  task automatic test_trc_off_and_reset();
    logic [W-1:0] exp_buf;
    exp_buf = '0;
    for (int i = 0; i < 3; i++) begin
      exp_buf = {exp_buf[W-3:0], code_of(i + 80)};
      send_code(code_of(i + 80));
    end
    bus.trc_on = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (bus.dct_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL trc_off_ready: cycle %0d got %0b want 1", i, bus.dct_in_ready);
      end
      send_code(code_of(i));
    end
    n_checks++;
    if (bus.dct_count !== 4'd3 || bus.dct_buffer !== exp_buf) begin
      n_fail++;
      $display("FAIL trc_off_acc: got cnt=%0d buf=%h want 3 %h", bus.dct_count, bus.dct_buffer, exp_buf);
    end
    bus.trc_on    = 1'b1;
    bus.pkt_ready = 1'b0;
    for (int i = 0; i < 14; i++) send_code(code_of(i + 90));
    n_checks++;
    if (bus.pkt_valid !== 1'b1 || bus.dct_count !== 4'd2) begin
      n_fail++;
      $display("FAIL pre_reset: got valid=%0b cnt=%0d want 1 2", bus.pkt_valid, bus.dct_count);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.pkt_valid !== 1'b0 || bus.pkt_data !== '0 || bus.dct_count !== 4'd0 ||
        bus.dct_buffer !== '0 || bus.dct_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%0b data=%h cnt=%0d buf=%h rdy=%0b want all reset",
               bus.pkt_valid, bus.pkt_data, bus.dct_count, bus.dct_buffer, bus.dct_in_ready);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_flush();
    test_flush_empty();
    test_back_to_back_stall();
    test_flush_pending();
    test_trc_off_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/soc_system_cpu_s1_oci_dct_packer.md
# soc_system_cpu_s1_oci_dct_packer

Packs 2-bit data-compression-trace (DCT) codes from the Nios II OCI data-trace logic into a 15-slot shift buffer. Drives the live `dct_buffer`/`dct_count` pair consumed by the OCI test bench. Emits full or flushed buffers as packets to the downstream trace FIFO over a valid/ready handshake. A one-deep hold register lets accumulation continue while a packet waits.

## Interface
- `SLOTS`, default 15: codes per packet, legal range 2..15. Buffer width is `2*SLOTS`.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `trc_on`  in  1  trace enable; when low, incoming codes are accepted and discarded.
- `dct_in_valid`  in  1  code strobe.
- `dct_in_code`  in  2  DCT code.
- `dct_in_ready`  out  1  code accepted when valid && ready.
- `flush`  in  1  single-cycle request to emit a partial buffer.
- `pkt_valid`  out  1  hold register occupied.
- `pkt_data`  out  4+2*SLOTS  {count[3:0], buffer}.
- `pkt_ready`  in  1  downstream accept.
- `dct_buffer`  out  2*SLOTS  live accumulator contents.
- `dct_count`  out  4  live slot count, 0..SLOTS.

## Operation
- Accumulator: `acc_buf` and `acc_cnt`. Hold register: `pkt_data` plus `pkt_valid`. Flush latch: `flush_pend`.
- `dct_buffer` = `acc_buf` and `dct_count` = `acc_cnt`, both directly from registers.
- Accept occurs when `dct_in_valid && dct_in_ready && trc_on`. On accept: `acc_buf <= {acc_buf[2*SLOTS-3:0], code}`, `acc_cnt++`.
  - Newest code sits in bits [1:0]. Unused upper slots stay 0.
- Fill: an accept while `acc_cnt == SLOTS-1` loads the hold register with {SLOTS, shifted buffer}. At the same edge it clears `acc_buf` and `acc_cnt` to 0 and sets `pkt_valid`.
- `dct_in_ready` = !(`pkt_valid` && `acc_cnt == SLOTS-1`). It is a function of registered state only; there is no combinational path from `pkt_ready`.
- When `trc_on` is low, `dct_in_ready` is 1, codes are dropped, and the accumulator is unchanged.
- Flush:
  - `flush` sets `flush_pend`.
  - The flush executes when `flush_pend` (or `flush` this cycle) is set and `!pkt_valid`.
  - If the count after this cycle's accept is > 0, it loads the hold register with {count, buffer}, clears the accumulator, and clears `flush_pend`.
  - If the count is 0, it only clears `flush_pend`. No empty packet is ever emitted.
- Accept with flush in the same cycle: the accepted code is included in the flushed packet.
- Packet drain: when `pkt_valid && pkt_ready`, `pkt_valid` clears at the edge.
  - If a fill or flush loads the hold register in the same cycle, `pkt_valid` stays 1 with the new data.
  - That load is legal because the conservative rule is evaluated on the pre-edge `pkt_valid`. A fill with `pkt_valid` = 1 cannot occur, since ready was low.
- Flush arriving while `pkt_valid` = 1: `flush_pend` holds the request. The flush executes on the first cycle with `pkt_valid` = 0, using the accumulator contents at that time.
- `pkt_data` is stable while `pkt_valid && !pkt_ready`.

## Timing
- Reset values: `acc_buf` = 0, `acc_cnt` = 0, `pkt_valid` = 0, `pkt_data` = 0, `flush_pend` = 0, `dct_in_ready` = 1.
- Reset mid-packet discards both the accumulator and the hold register. There is no partial emission.
- Latency:
  - Accept to `dct_count` update: 1 cycle.
  - Final fill accept to `pkt_valid`: 1 cycle.
  - `flush` to `pkt_valid` with the hold register free: 1 cycle.
- Throughput: 1 code per cycle sustained while the downstream accepts each packet within SLOTS-1 cycles of its assertion.
- Stall: with the hold register occupied and `acc_cnt == SLOTS-1`, `dct_in_ready` is 0 until the cycle after `pkt_ready`.
- `acc_cnt` never exceeds SLOTS. It never wraps.

## Test plan
- Reset, then 15 consecutive codes 0,1,2,3,0,1,… with `pkt_ready` = 1 -> at cycle 16 `pkt_valid` = 1, `pkt_data[33:30]` = 15, `pkt_data[1:0]` = 2 (15th code), `pkt_data[29:28]` = 0; `dct_count` = 0.
- 5 codes (3,3,1,0,2), then `flush` -> `pkt_data` = {4'd5, 20'b0, 10'b11_11_01_00_10} one cycle later; accumulator cleared.
- `flush` with `dct_count` = 0 -> `pkt_valid` stays 0; `flush_pend` = 0 next cycle.
- `pkt_ready` = 0, stream 30 codes -> first packet holds. After 14 further accepts, `dct_in_ready` = 0 and `dct_count` = 14. Raising `pkt_ready` releases the stall; the second packet carries codes 16..30 in order.
- `flush` while `pkt_valid` = 1 and `pkt_ready` = 0, then 2 more codes, then `pkt_ready` -> the second packet has count = (pre-flush count + 2).
- `trc_on` = 0 with 10 valid codes -> `dct_in_ready` = 1, `dct_count` unchanged. Then assert `reset` mid-packet with `pkt_valid` = 1 -> all outputs return to reset values asynchronously.
